instr_load_ctrl: RTL

INSTR_LOAD_CTRL -- requirements
Module: instr_load_ctrl

---
 rtl/hdu_risc_pkg.sv | 13 +
 rtl/instr_load_ctrl_if.sv | 29 ++
 rtl/btn_sync_edge.sv | 32 +++
 rtl/instr_load_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/hdu_risc_pkg.sv
// Shared definitions for the instruction loader: memory geometry defaults and FSM encodings.
package hdu_risc_pkg;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultAw    = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_load_ctrl_if.sv
// Host-facing bundle of the instruction loader: switch/button/request inputs and memory/CPU outputs.
interface instr_load_ctrl_if #(
  parameter int unsigned AW = hdu_risc_pkg::DefaultAw
) ();

  logic [7:0]  input_val;
  logic        but_inp;
  logic        load_req;
  logic        run_req;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [AW:0] prog_len;
  logic        cpu_hold;
  logic        loading;

  // Host side: drives switches, button and requests; observes the loader.
  modport master (
    output input_val, but_inp, load_req, run_req,
    input  mem_we, mem_addr, mem_wdata, prog_len, cpu_hold, loading
  );

  // Loader side.
  modport slave (
    input  input_val, but_inp, load_req, run_req,
    output mem_we, mem_addr, mem_wdata, prog_len, cpu_hold, loading
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for a raw push-button.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic pulse
);

  logic       sync1_q, sync2_q, prev_q, pulse_q;
  // valid_q[i] marks that stage i holds a real post-reset sample, so a button held
  // through reset release is seen as already-high rather than as a fresh press.
  logic [2:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      valid_q <= 3'b000;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= d_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= {valid_q[1:0], 1'b1};
      pulse_q <= valid_q[2] & sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/instr_load_ctrl.sv
// Instruction loader: writes switch bytes into instruction memory on button presses,
// then releases the CPU pipeline once loading ends.
module instr_load_ctrl
  import hdu_risc_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = DefaultAw
) (
  input logic              clk,
  input logic              rst,
  instr_load_ctrl_if.slave bus
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneCount  = {{AW{1'b0}}, 1'b1};

  load_state_e   state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          loading_q, loading_d;
  logic          btn_pulse;
  logic          full;

  btn_sync_edge u_btn_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .d_async (bus.but_inp),
    .pulse   (btn_pulse)
  );

  assign full = (count_q == FullCount);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prog_len_d  = prog_len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.load_req) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        // The full check keeps the pointer from ever wrapping past DEPTH-1.
        if (btn_pulse && !full) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q[AW-1:0];
          mem_wdata_d = bus.input_val;
          count_d     = count_q + OneCount;
        end
        // count_d already includes a coincident write, so prog_len counts it.
        if (bus.run_req || full) begin
          state_d    = StRun;
          prog_len_d = count_d;
        end
      end
      StRun: begin
        if (bus.load_req) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    cpu_hold_d = (state_d != StRun);
    loading_d  = (state_d == StLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      prog_len_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      loading_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prog_len_q  <= prog_len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      loading_q   <= loading_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.prog_len  = prog_len_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.loading   = loading_q;

endmodule
